// File: rtl/xgmii_pkg.sv
// -----------------------------------------------------------------------------
// xgmii_pkg
// Shared XGMII constants and the transmit-arbiter state encoding.
// Contents:
//   XGMII_* control characters, full 72-bit {txc, txd} idle and error columns,
//   tx_state_e : IDLE / FRAME / ABORT / IFG.
// -----------------------------------------------------------------------------
package xgmii_pkg;

  localparam logic [7:0] XGMII_START = 8'hfb;
  localparam logic [7:0] XGMII_TERM  = 8'hfd;
  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_ERR   = 8'hfe;

  // Column layout is {txc[7:0], txd[63:0]}; lane 0 is the low byte.
  localparam logic [71:0] XGMII_IDLE_WORD  = {8'hff, 64'h0707070707070707};
  localparam logic [71:0] XGMII_ERROR_WORD = {8'hff, 64'h07070707070707fe};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_ABORT = 2'd2,
    ST_IFG   = 2'd3
  } tx_state_e;

endpackage

// File: rtl/xgmii_tx_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin selector. Searches upward from the entry after
// i_ptr, wrapping at N, and reports the first requester found.
// Ports:
//   i_req   [N-1:0]     request vector
//   i_ptr   [IDX_W-1:0] index of the most recently served requester
//   o_grant [N-1:0]     one-hot winner (all zero when nobody requests)
//   o_idx   [IDX_W-1:0] binary index of the winner (0 when none)
//   o_valid             at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // Round-robin search: offset 1 is highest priority, offset N (the pointer
  // itself) is lowest, so the last winner only wins again when alone.
  always_comb begin
    int cand;
    cand    = 0;
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int off = 1; off <= N; off++) begin
      cand = (int'(i_ptr) + off) % N;
      if (!o_valid && i_req[cand]) begin
        o_valid       = 1'b1;
        o_grant[cand] = 1'b1;
        o_idx         = IDX_W'(cand);
      end else begin
        o_valid = o_valid;
      end
    end
  end

endmodule

// File: rtl/xgmii_tx_arbiter.sv
// -----------------------------------------------------------------------------
// xgmii_tx_arbiter
// Shares one XGMII transmit path between NUM_SRC frame generators. Whole
// frames are granted round-robin, the granted source's columns are forwarded
// through one register stage, a minimum inter-frame gap of idle columns is
// forced after every frame, and a watchdog aborts frames that never terminate.
// Ports:
//   xgmii_clk, sys_rst         clock, synchronous active-high reset
//   src_req   [NUM_SRC-1:0]    per-source frame request (level)
//   src_grant [NUM_SRC-1:0]    one-hot grant, held for the whole frame
//   src_txd   [64*NUM_SRC-1:0] per-source data, source i at [64i+63:64i]
//   src_txc   [8*NUM_SRC-1:0]  per-source control, source i at [8i+7:8i]
//   xgmii_txd/xgmii_txc        registered XGMII transmit column
//   busy                       high whenever not in IDLE
//   cur_src   [2:0]            granted / last-granted source index
//   frame_count [31:0]         completed frames, wraps
//   abort_count [15:0]         watchdog aborts, saturates
// -----------------------------------------------------------------------------
module xgmii_tx_arbiter
  import xgmii_pkg::*;
#(
  parameter int NUM_SRC         = 2,
  parameter int MIN_IFG_WORDS   = 2,
  parameter int MAX_FRAME_WORDS = 1024
) (
  input  logic                   xgmii_clk,
  input  logic                   sys_rst,
  input  logic [NUM_SRC-1:0]     src_req,
  output logic [NUM_SRC-1:0]     src_grant,
  input  logic [64*NUM_SRC-1:0]  src_txd,
  input  logic [8*NUM_SRC-1:0]   src_txc,
  output logic [63:0]            xgmii_txd,
  output logic [7:0]             xgmii_txc,
  output logic                   busy,
  output logic [2:0]             cur_src,
  output logic [31:0]            frame_count,
  output logic [15:0]            abort_count
);

  localparam logic [15:0] WCNT_LAST = 16'(MAX_FRAME_WORDS - 1);
  localparam logic [15:0] IFG_LAST  = 16'(MIN_IFG_WORDS - 1);
  localparam logic [2:0]  PTR_RST   = 3'(NUM_SRC - 1);

  tx_state_e            r_state;
  logic [NUM_SRC-1:0]   r_grant;
  logic [2:0]           r_ptr;
  logic [2:0]           r_cur_src;
  logic [15:0]          r_wcnt;
  logic [15:0]          r_ifg_cnt;
  logic [71:0]          r_out;
  logic                 r_busy;
  logic [31:0]          r_frame_cnt;
  logic [15:0]          r_abort_cnt;

  logic [NUM_SRC-1:0]   w_arb_grant;
  logic [2:0]           w_arb_idx;
  logic                 w_arb_valid;
  logic [63:0]          w_sel_txd;
  logic [7:0]           w_sel_txc;
  logic                 w_term;

  rr_arbiter #(
    .N     (NUM_SRC),
    .IDX_W (3)
  ) u_rr (
    .i_req   (src_req),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  // Word mux: the grant is one-hot, so at most one source is selected.
  always_comb begin
    w_sel_txd = 64'h0;
    w_sel_txc = 8'h0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_grant[i]) begin
        w_sel_txd = src_txd[64*i +: 64];
        w_sel_txc = src_txc[8*i +: 8];
      end else begin
        w_sel_txd = w_sel_txd;
        w_sel_txc = w_sel_txc;
      end
    end
  end

  // Terminate detection: any control lane carrying the terminate character.
  always_comb begin
    w_term = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (w_sel_txc[k] && (w_sel_txd[8*k +: 8] == XGMII_TERM)) begin
        w_term = 1'b1;
      end else begin
        w_term = w_term;
      end
    end
  end

  // Main FSM with registered grant, output column, status and counters.
  always_ff @(posedge xgmii_clk) begin
    if (sys_rst) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_ptr       <= PTR_RST;
      r_cur_src   <= 3'd0;
      r_wcnt      <= 16'd0;
      r_ifg_cnt   <= 16'd0;
      r_out       <= XGMII_IDLE_WORD;
      r_busy      <= 1'b0;
      r_frame_cnt <= 32'd0;
      r_abort_cnt <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_out <= XGMII_IDLE_WORD;
          if (w_arb_valid) begin
            r_grant   <= w_arb_grant;
            r_cur_src <= w_arb_idx;
            r_ptr     <= w_arb_idx;
            r_wcnt    <= 16'd0;
            r_busy    <= 1'b1;
            r_state   <= ST_FRAME;
          end else begin
            r_busy <= 1'b0;
          end
        end

        ST_FRAME: begin
          if (w_term) begin
            r_out       <= {w_sel_txc, w_sel_txd};
            r_frame_cnt <= r_frame_cnt + 32'd1;
            r_grant     <= '0;
            r_ifg_cnt   <= 16'd0;
            r_state     <= ST_IFG;
          end else if (r_wcnt == WCNT_LAST) begin
            // Watchdog expiry: this cycle's source word is dropped and the
            // error column follows from ABORT.
            r_out   <= XGMII_IDLE_WORD;
            r_state <= ST_ABORT;
          end else begin
            r_out  <= {w_sel_txc, w_sel_txd};
            r_wcnt <= r_wcnt + 16'd1;
          end
        end

        ST_ABORT: begin
          r_out     <= XGMII_ERROR_WORD;
          r_grant   <= '0;
          r_ifg_cnt <= 16'd0;
          r_state   <= ST_IFG;
          if (r_abort_cnt != 16'hffff) begin
            r_abort_cnt <= r_abort_cnt + 16'd1;
          end else begin
            r_abort_cnt <= r_abort_cnt;
          end
        end

        ST_IFG: begin
          r_out <= XGMII_IDLE_WORD;
          if (r_ifg_cnt == IFG_LAST) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_ifg_cnt <= r_ifg_cnt + 16'd1;
          end
        end

        default: begin
          r_out   <= XGMII_IDLE_WORD;
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign src_grant   = r_grant;
  assign xgmii_txc   = r_out[71:64];
  assign xgmii_txd   = r_out[63:0];
  assign busy        = r_busy;
  assign cur_src     = r_cur_src;
  assign frame_count = r_frame_cnt;
  assign abort_count = r_abort_cnt;

endmodule

// File: tb/tb_xgmii_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_xgmii_tx_arbiter
// Randomised traffic from three sources (terminating frames with leading
// idles, endless frames that trip the watchdog, mid-frame request withdrawal)
// against a frame-level reference: each granted frame contributes its
// non-idle columns (or a truncated copy plus an error column) to a queue that
// a monitor drains as the DUT emits non-idle columns. Grant order, gap length,
// counters, reset and mid-frame reset are checked too.
// -----------------------------------------------------------------------------
module tb_xgmii_tx_arbiter;

  localparam int NS   = 3;
  localparam int MINI = 2;
  localparam int MAXW = 16;
  localparam logic [71:0] IDLE_W = {8'hff, 64'h0707070707070707};
  localparam logic [71:0] ERR_W  = {8'hff, 64'h07070707070707fe};

  logic              clk = 1'b0;
  logic              sys_rst;
  logic [NS-1:0]     src_req;
  logic [NS-1:0]     src_grant;
  logic [64*NS-1:0]  src_txd;
  logic [8*NS-1:0]   src_txc;
  logic [63:0]       xgmii_txd;
  logic [7:0]        xgmii_txc;
  logic              busy;
  logic [2:0]        cur_src;
  logic [31:0]       frame_count;
  logic [15:0]       abort_count;

  xgmii_tx_arbiter #(
    .NUM_SRC         (NS),
    .MIN_IFG_WORDS   (MINI),
    .MAX_FRAME_WORDS (MAXW)
  ) dut (
    .xgmii_clk   (clk),
    .sys_rst     (sys_rst),
    .src_req     (src_req),
    .src_grant   (src_grant),
    .src_txd     (src_txd),
    .src_txc     (src_txc),
    .xgmii_txd   (xgmii_txd),
    .xgmii_txc   (xgmii_txc),
    .busy        (busy),
    .cur_src     (cur_src),
    .frame_count (frame_count),
    .abort_count (abort_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Scoreboard state
  logic [71:0] exp_q[$];
  bit          last_q[$];
  bit          sb_en = 1'b0;
  int          exp_frames = 0;
  int          exp_aborts = 0;
  logic [NS-1:0] last_req;

  // Source model state
  logic [71:0] frm [NS][48];
  int          flen    [NS];
  bit          term_f  [NS];
  bit          act     [NS];
  int          idx     [NS];
  int          wait_c  [NS];
  int          drop_at [NS];
  logic [NS-1:0] req_v;
  bit          gen = 1'b0;

  always @(posedge clk) last_req <= src_req;

  task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [71:0] data_word();
    return {8'h00, $urandom(), $urandom()};
  endfunction

  // Build the next frame for source i: 0..2 idles, start, data, terminate;
  // one in six frames never terminates.
  task automatic new_frame(input int i);
    logic [63:0] d;
    logic [7:0]  c;
    int n, k, nd;
    n = 0;
    for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
      frm[i][n] = IDLE_W; n++;
    end
    d = {$urandom(), $urandom()};
    d[7:0] = 8'hfb;
    frm[i][n] = {8'h01, d}; n++;
    term_f[i] = ($urandom_range(0, 5) != 0);
    nd = term_f[i] ? int'($urandom_range(1, 8)) : 30;
    for (int j = 0; j < nd; j++) begin
      frm[i][n] = data_word(); n++;
    end
    if (term_f[i]) begin
      k = int'($urandom_range(0, 7));
      d = {$urandom(), $urandom()};
      c = 8'h00;
      for (int j = 0; j < 8; j++) begin
        if (j == k) begin d[8*j +: 8] = 8'hfd; c[j] = 1'b1; end
        else if (j > k) begin d[8*j +: 8] = 8'h07; c[j] = 1'b1; end
      end
      frm[i][n] = {c, d}; n++;
    end
    flen[i]    = n;
    drop_at[i] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 8)) : 99;
  endtask

  // Expected transmit for one granted frame.
  task automatic push_frame(input int i);
    for (int t = 0; t < flen[i]; t++) begin
      if (!term_f[i] && t == MAXW - 1) begin
        exp_q.push_back(ERR_W);
        last_q.push_back(1'b1);
        break;
      end
      if (frm[i][t] != IDLE_W) begin
        exp_q.push_back(frm[i][t]);
        last_q.push_back(term_f[i] && (t == flen[i] - 1));
      end
    end
    if (term_f[i]) exp_frames++;
    else exp_aborts++;
  endtask

  // One source-model cycle, driven at the falling edge.
  task automatic drive_step();
    logic [71:0]      w;
    logic [64*NS-1:0] td;
    logic [8*NS-1:0]  tc;
    @(negedge clk);
    for (int i = 0; i < NS; i++) begin
      w = IDLE_W;
      if (src_grant[i]) begin
        if (!act[i]) begin
          act[i] = 1'b1; idx[i] = 0; push_frame(i);
        end
        if (idx[i] < flen[i]) w = frm[i][idx[i]];
        idx[i]++;
        if (idx[i] == drop_at[i]) req_v[i] = 1'b0;
      end else if (act[i]) begin
        act[i] = 1'b0; req_v[i] = 1'b0;
        wait_c[i] = int'($urandom_range(0, 6));
        new_frame(i);
      end else if (!req_v[i] && gen) begin
        if (wait_c[i] > 0) wait_c[i]--;
        else req_v[i] = 1'b1;
      end
      td[64*i +: 64] = w[63:0];
      tc[8*i +: 8]   = w[71:64];
    end
    src_req = req_v; src_txd = td; src_txc = tc;
  endtask

  // Monitor: pops the scoreboard on every non-idle output column.
  initial begin
    logic [71:0]   w, e;
    logic [NS-1:0] prev_grant, eg;
    bit            l, after_end;
    int            gap, last_win, ew;
    prev_grant = '0; after_end = 1'b0; gap = 0; last_win = NS - 1;
    forever begin
      @(posedge clk); #1;
      if (sb_en) begin
        w = {xgmii_txc, xgmii_txd};
        if (src_grant != '0 && prev_grant == '0) begin
          ew = -1;
          for (int k = 1; k <= NS; k++) begin
            if (ew < 0 && last_req[(last_win + k) % NS]) ew = (last_win + k) % NS;
          end
          vectors++;
          if (ew < 0) begin
            errors++;
            $display("FAIL grant_no_req got %b expected no grant", src_grant);
          end else begin
            eg = '0; eg[ew] = 1'b1;
            if (src_grant !== eg || cur_src !== 3'(ew)) begin
              errors++;
              $display("FAIL grant_order got %b/%0d expected %b/%0d", src_grant, cur_src, eg, ew);
            end
            last_win = ew;
          end
        end
        if (w != IDLE_W) begin
          vectors++;
          l = 1'b0;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word got %h expected none", w);
          end else begin
            e = exp_q.pop_front();
            l = last_q.pop_front();
            if (w !== e) begin
              errors++;
              $display("FAIL tx_word got %h expected %h", w, e);
            end
          end
          if (after_end) begin
            vectors++;
            if (gap < MINI + 1) begin
              errors++;
              $display("FAIL ifg_gap got %0d expected >= %0d", gap, MINI + 1);
            end
          end
          after_end = l;
          gap = 0;
        end else begin
          gap++;
        end
      end
      prev_grant = src_grant;
    end
  end

  initial begin
    bit drained, got;
    sys_rst = 1'b1;
    req_v = '0;
    for (int i = 0; i < NS; i++) begin
      act[i] = 1'b0; idx[i] = 0; wait_c[i] = int'($urandom_range(0, 4));
      new_frame(i);
    end
    // Reset with random source activity
    repeat (3) begin
      @(negedge clk);
      src_req = NS'($urandom());
      src_txd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      src_txc = 24'($urandom());
    end
    @(posedge clk); #1;
    chk("rst_txc",   72'(xgmii_txc), 72'(8'hff));
    chk("rst_txd",   72'(xgmii_txd), 72'(64'h0707070707070707));
    chk("rst_grant", 72'(src_grant), 72'(0));
    chk("rst_busy",  72'(busy), 72'(0));
    chk("rst_cur",   72'(cur_src), 72'(0));
    chk("rst_fcnt",  72'(frame_count), 72'(0));
    chk("rst_acnt",  72'(abort_count), 72'(0));
    @(negedge clk);
    sys_rst = 1'b0; src_req = '0;
    src_txd = {NS{IDLE_W[63:0]}}; src_txc = {NS{IDLE_W[71:64]}};

    // Random traffic
    sb_en = 1'b1;
    gen   = 1'b1;
    repeat (1500) drive_step();
    gen = 1'b0;
    drained = 1'b0;
    for (int c = 0; c < 500 && !drained; c++) begin
      drive_step();
      drained = (src_req == '0) && !busy && (exp_q.size() == 0) &&
                !act[0] && !act[1] && !act[2];
    end
    vectors++;
    if (!drained) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending expected 0", exp_q.size());
    end
    chk("frame_count", 72'(frame_count), 72'(32'(exp_frames)));
    chk("abort_count", 72'(abort_count), 72'(16'(exp_aborts)));
    sb_en = 1'b0;

    // Reset in the middle of a frame from source 0
    @(negedge clk);
    src_req = 3'b001;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(posedge clk); #1;
      got = src_grant[0];
    end
    chk("mid_grant0", 72'(src_grant), 72'(3'b001));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      src_txd[63:0] = (k == 0) ? 64'h55443322110000fb : {$urandom(), $urandom()};
      src_txc[7:0]  = (k == 0) ? 8'h01 : 8'h00;
      if (k == 4) sys_rst = 1'b1;
    end
    @(posedge clk); #1;
    chk("mid_rst_word",  {xgmii_txc, xgmii_txd}, IDLE_W);
    chk("mid_rst_grant", 72'(src_grant), 72'(0));
    chk("mid_rst_busy",  72'(busy), 72'(0));
    chk("mid_rst_fcnt",  72'(frame_count), 72'(0));
    chk("mid_rst_acnt",  72'(abort_count), 72'(0));
    @(negedge clk);
    sys_rst = 1'b0; src_req = 3'b010;
    src_txd[63:0] = IDLE_W[63:0]; src_txc[7:0] = IDLE_W[71:64];
    @(posedge clk); #1;
    chk("post_rst_grant", 72'(src_grant), 72'(3'b010));
    chk("post_rst_cur",   72'(cur_src), 72'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
